// File: rtl/regfile_sb.sv
// Purpose: parametrised register file (NREAD comb read ports, 1 sync write port, optional bypass, zero reg) with per-register busy scoreboard.
// Latency: reads are combinational (0 cycles); writes and scoreboard updates take effect at the next posedge clk.
// Backpressure: none; the issue stage consumes rd_busy/busy_vec and stalls itself on RAW hazards.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en/addr/data   writeback write port; also clears the destination's busy bit
//   rd_addr, rd_data  packed read ports, port i at [i*AW +: AW] / [i*XLEN +: XLEN]
//   rd_busy           per read port: addressed register still has an unresolved producer
//   sb_set, sb_addr   issue marks a destination register as pending
//   flush             clears every busy bit
//   busy_vec          registered scoreboard, pend_cnt = popcount(busy_vec)
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec,
  output logic [AW:0]           pend_cnt
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW-1:0]    rd_addr_a [NREAD];

  logic wr_ok;
  assign wr_ok = wr_en && !(ZR && (wr_addr == '0));

  // Register data next state: writes to the hardwired zero register are dropped.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Scoreboard next state. Priority: flush, then issue set, then writeback clear.
  // Set beats clear so that a newer producer issued in the same cycle an older
  // one retires to the same register keeps the register busy (WAW).
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (sb_set && (sb_addr == AW'(r)) && !(ZR && (r == 0))) begin
        busy_d[r] = 1'b1;
      end else if (wr_en && (wr_addr == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // Read ports. A same-cycle write to the addressed register is forwarded
  // (when bypass is enabled) and also resolves its busy bit for this read.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_addr_a[i] = rd_addr[i*AW +: AW];
      if (ZR && (rd_addr_a[i] == '0)) begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_busy[i]              = 1'b0;
      end else if (BP && wr_en && (wr_addr == rd_addr_a[i])) begin
        rd_data[i*XLEN +: XLEN] = wr_data;
        rd_busy[i]              = 1'b0;
      end else begin
        rd_data[i*XLEN +: XLEN] = regs_q[rd_addr_a[i]];
        rd_busy[i]              = busy_q[rd_addr_a[i]];
      end
    end
  end

  assign busy_vec = busy_q;

  // Population count of the registered scoreboard.
  always_comb begin
    pend_cnt = '0;
    for (int r = 0; r < NREGS; r++) begin
      pend_cnt = pend_cnt + {{AW{1'b0}}, busy_q[r]};
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Purpose: directed self-checking bench for regfile_sb; two instances (bypass on / off) share all inputs.
// Latency: inputs driven 1 time unit after posedge, outputs sampled a few units later, before the next posedge.
// Backpressure: not applicable.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk;
  logic                  rst_n;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic [NREAD*AW-1:0]   rd_addr;
  logic                  sb_set;
  logic [AW-1:0]         sb_addr;
  logic                  flush;

  logic [NREAD*XLEN-1:0] rd_data_a, rd_data_b;
  logic [NREAD-1:0]      rd_busy_a, rd_busy_b;
  logic [NREGS-1:0]      busy_vec_a, busy_vec_b;
  logic [AW:0]           pend_cnt_a, pend_cnt_b;

  int total = 0;
  int bad   = 0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1), .ZERO_REG(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush),
    .busy_vec(busy_vec_a), .pend_cnt(pend_cnt_a)
  );

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0), .ZERO_REG(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush),
    .busy_vec(busy_vec_b), .pend_cnt(pend_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 unit after the next posedge and drop all strobes.
  task automatic step();
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    sb_set = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic sb(input logic [AW-1:0] a);
    sb_set  = 1'b1;
    sb_addr = a;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; sb_set = 1'b0; sb_addr = '0; flush = 1'b0;

    // Reset state
    step(); step();
    rd2(5'd5, 5'd7);
    #2;
    chk("rst_rd0", rd_data_a[31:0], 64'h0);
    chk("rst_rd1", rd_data_a[63:32], 64'h0);
    chk("rst_busy", rd_busy_a, 64'h0);
    chk("rst_bvec", busy_vec_a, 64'h0);
    chk("rst_pend", pend_cnt_a, 64'h0);
    rst_n = 1'b1;

    // Write r5 (with sb_set r5, set wins), then async reset mid-cycle
    step();
    wr(5'd5, 32'hDEADBEEF); sb(5'd5);
    step();
    rd2(5'd5, 5'd5);
    #1;
    chk("pre_rst_rd", rd_data_a[31:0], 64'hDEADBEEF);
    chk("pre_rst_bvec", busy_vec_a, 64'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd", rd_data_a[31:0], 64'h0);
    chk("async_rst_bvec", busy_vec_a, 64'h0);
    step();
    rst_n = 1'b1;

    // Zero register: write and sb_set to r0 are ignored
    step();
    wr(5'd0, 32'h1234); sb(5'd0); rd2(5'd0, 5'd0);
    #1;
    chk("zero_byp_rd0", rd_data_a[31:0], 64'h0);
    chk("zero_byp_rd1", rd_data_a[63:32], 64'h0);
    step();
    #1;
    chk("zero_rd0", rd_data_a[31:0], 64'h0);
    chk("zero_rd1", rd_data_a[63:32], 64'h0);
    chk("zero_busy", rd_busy_a, 64'h0);
    chk("zero_pend", pend_cnt_a, 64'h0);

    // Bypass: preload r3 = 0x11, then write 0x22 while both ports read r3
    wr(5'd3, 32'h11);
    step();
    wr(5'd3, 32'h22); rd2(5'd3, 5'd3);
    #1;
    chk("byp_a_rd0", rd_data_a[31:0], 64'h22);
    chk("byp_a_rd1", rd_data_a[63:32], 64'h22);
    chk("byp_a_busy", rd_busy_a, 64'h0);
    chk("nobyp_b_rd0", rd_data_b[31:0], 64'h11);
    chk("nobyp_b_rd1", rd_data_b[63:32], 64'h11);
    step();
    #1;
    chk("nobyp_b_next", rd_data_b[31:0], 64'h22);
    chk("nobyp_b_next1", rd_data_b[63:32], 64'h22);

    // Scoreboard: set r7, then retire it
    sb(5'd7); rd2(5'd7, 5'd7);
    #1;
    chk("sb_same_cycle", rd_busy_a, 64'h0);
    step();
    #1;
    chk("sb_busy", rd_busy_a, 64'h3);
    chk("sb_pend", pend_cnt_a, 64'h1);
    wr(5'd7, 32'h55);
    #1;
    chk("sb_wr_busy_a", rd_busy_a, 64'h0);
    chk("sb_wr_busy_b", rd_busy_b, 64'h3);
    chk("sb_wr_byp", rd_data_a[31:0], 64'h55);
    step();
    #1;
    chk("sb_clr_bvec", busy_vec_a, 64'h0);
    chk("sb_clr_pend", pend_cnt_a, 64'h0);
    chk("sb_clr_rd", rd_data_a[31:0], 64'h55);

    // WAW: r9 busy, same-cycle set and write keeps it busy
    sb(5'd9);
    step();
    sb(5'd9); wr(5'd9, 32'h99);
    step();
    rd2(5'd9, 5'd3);
    #1;
    chk("waw_bvec", busy_vec_a, 64'h200);
    chk("waw_busy", rd_busy_a, 64'h1);
    chk("waw_rd", rd_data_a[31:0], 64'h99);
    chk("waw_rd_other", rd_data_a[63:32], 64'h22);

    // Flush: retire r9, set r1, r2, r4 (r2 twice), then flush with sb_set r6
    sb(5'd1); wr(5'd9, 32'h99);
    step();
    sb(5'd2);
    step();
    sb(5'd4);
    step();
    sb(5'd2);
    step();
    #1;
    chk("fl_pre_bvec", busy_vec_a, 64'h16);
    chk("fl_pre_pend", pend_cnt_a, 64'h3);
    flush = 1'b1; sb(5'd6); wr(5'd10, 32'hAB);
    step();
    rd2(5'd10, 5'd6);
    #1;
    chk("fl_bvec", busy_vec_a, 64'h0);
    chk("fl_pend", pend_cnt_a, 64'h0);
    chk("fl_busy", rd_busy_a, 64'h0);
    chk("fl_wr_data", rd_data_a[31:0], 64'hAB);
    chk("fl_b_bvec", busy_vec_b, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
